// File: rtl/contador_varredura_xy_pkg.sv
// rtl/contador_varredura_xy_pkg.sv - shared FSM encoding and default widths for the XY scan counter
package contador_pkg;

    localparam int LARG_BITS_DEF  = 10;
    localparam int ALT_BITS_DEF   = 10;
    localparam int PASSO_BITS_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIM  = 2'd2
    } estado_t;

endpackage

// File: rtl/contador_varredura_xy_if.sv
// rtl/contador_varredura_xy_if.sv - control/coordinate bundle of the XY scan counter (fator only with ZOOM_REPEAT_EN)
interface contador_varredura_xy_if #(
    parameter int W_BITS = 10,
    parameter int H_BITS = 10,
    parameter int P_BITS = 3
);
    logic              config_mudou;
    logic              start;
    logic              enable;
    logic [W_BITS-1:0] largura_max;
    logic [H_BITS-1:0] altura_max;
    logic [P_BITS-1:0] passo;
`ifdef ZOOM_REPEAT_EN
    logic [P_BITS-1:0] fator;
`endif
    logic [W_BITS-1:0] cont_x;
    logic [H_BITS-1:0] cont_y;
    logic              valid;
    logic              fim_linha;
    logic              fim_quadro;
    logic              busy;
    logic              done;
    logic              erro;

    modport master (
`ifdef ZOOM_REPEAT_EN
        output fator,
`endif
        output config_mudou, start, enable, largura_max, altura_max, passo,
        input  cont_x, cont_y, valid, fim_linha, fim_quadro, busy, done, erro
    );

    modport slave (
`ifdef ZOOM_REPEAT_EN
        input  fator,
`endif
        input  config_mudou, start, enable, largura_max, altura_max, passo,
        output cont_x, cont_y, valid, fim_linha, fim_quadro, busy, done, erro
    );

endinterface

// File: rtl/contador_varredura_xy_eixo.sv
// rtl/contador_varredura_xy_eixo.sv - one scan axis: stepped counter with latched limit and wrap flag
module contador_eixo #(
    parameter int N = 10,
    parameter int P = 3
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         load,
    input  logic         avanca,
    input  logic [N-1:0] max_in,
    input  logic [P-1:0] passo,
    output logic [N-1:0] cont,
    output logic         wrap
);

    logic [N-1:0] max_q;
    logic [N:0]   soma;

    // One extra bit so the compare happens before any truncation can alias.
    assign soma = {1'b0, cont} + (N+1)'(passo);
    assign wrap = (soma >= {1'b0, max_q});

    // Counter and limit latch; load restarts at 0, advance wraps past the limit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cont  <= '0;
            max_q <= '0;
        end else if (clear) begin
            cont  <= '0;
        end else if (load) begin
            cont  <= '0;
            max_q <= max_in;
        end else if (avanca) begin
            cont  <= wrap ? '0 : soma[N-1:0];
        end
    end

endmodule

// File: rtl/contador_varredura_xy.sv
// rtl/contador_varredura_xy.sv - 2-D scan counter top; optional pixel replication under ZOOM_REPEAT_EN
module contador_varredura_xy
    import contador_pkg::*;
#(
    parameter int W_BITS = LARG_BITS_DEF,
    parameter int H_BITS = ALT_BITS_DEF,
    parameter int P_BITS = PASSO_BITS_DEF
) (
    input  logic                     clock,
    input  logic                     reset_n,
    contador_varredura_xy_if.slave   bus
);

    estado_t           estado_q, estado_d;
    logic [P_BITS-1:0] passo_q;
    logic              carga, avanca, done_d, erro_d;
    logic              done_q, erro_q;
    logic              x_wrap, y_wrap;
    logic              rep_x_ult, rep_l_ult;
    logic              ultimo;
    logic              x_avanca, y_avanca;

`ifdef ZOOM_REPEAT_EN
    logic [P_BITS-1:0] fator_q, rep_x_q, rep_l_q, fator_m1;

    assign fator_m1  = fator_q - {{(P_BITS-1){1'b0}}, 1'b1};
    assign rep_x_ult = (rep_x_q == fator_m1);
    assign rep_l_ult = (rep_l_q == fator_m1);

    // Repeat counters: hold each x for f enables, sweep each line f times.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fator_q <= '0;
            rep_x_q <= '0;
            rep_l_q <= '0;
        end else if (bus.config_mudou) begin
            rep_x_q <= '0;
            rep_l_q <= '0;
        end else if (carga) begin
            fator_q <= (bus.fator == '0) ? {{(P_BITS-1){1'b0}}, 1'b1} : bus.fator;
            rep_x_q <= '0;
            rep_l_q <= '0;
        end else if (avanca && !ultimo) begin
            if (!rep_x_ult) begin
                rep_x_q <= rep_x_q + {{(P_BITS-1){1'b0}}, 1'b1};
            end else begin
                rep_x_q <= '0;
                if (x_wrap) begin
                    rep_l_q <= rep_l_ult ? '0 : rep_l_q + {{(P_BITS-1){1'b0}}, 1'b1};
                end
            end
        end
    end
`else
    assign rep_x_ult = 1'b1;
    assign rep_l_ult = 1'b1;
`endif

    assign ultimo   = x_wrap && y_wrap && rep_x_ult && rep_l_ult;
    // At the last position the counters freeze so FIM still shows it.
    assign x_avanca = avanca && rep_x_ult && !ultimo;
    assign y_avanca = x_avanca && x_wrap && rep_l_ult;

    contador_eixo #(.N(W_BITS), .P(P_BITS)) u_eixo_x (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (bus.config_mudou),
        .load    (carga),
        .avanca  (x_avanca),
        .max_in  (bus.largura_max),
        .passo   (passo_q),
        .cont    (bus.cont_x),
        .wrap    (x_wrap)
    );

    contador_eixo #(.N(H_BITS), .P(P_BITS)) u_eixo_y (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (bus.config_mudou),
        .load    (carga),
        .avanca  (y_avanca),
        .max_in  (bus.altura_max),
        .passo   (passo_q),
        .cont    (bus.cont_y),
        .wrap    (y_wrap)
    );

    // Step latch; a zero step is promoted to 1 so the scan always progresses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            passo_q <= '0;
        end else if (carga) begin
            passo_q <= (bus.passo == '0) ? {{(P_BITS-1){1'b0}}, 1'b1} : bus.passo;
        end
    end

    // State register plus the registered done/erro pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= ST_IDLE;
            done_q   <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            done_q   <= done_d;
            erro_q   <= erro_d;
        end
    end

    // Next-state logic; config_mudou overrides everything and suppresses done.
    always_comb begin
        estado_d = estado_q;
        carga    = 1'b0;
        avanca   = 1'b0;
        done_d   = 1'b0;
        erro_d   = 1'b0;
        if (bus.config_mudou) begin
            estado_d = ST_IDLE;
        end else begin
            unique case (estado_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.largura_max == '0 || bus.altura_max == '0) begin
                            erro_d = 1'b1;
                        end else begin
                            carga    = 1'b1;
                            estado_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.enable) begin
                        avanca = 1'b1;
                        if (ultimo) begin
                            estado_d = ST_FIM;
                            done_d   = 1'b1;
                        end
                    end
                end
                ST_FIM: begin
                    estado_d = ST_IDLE;
                end
                default: begin
                    estado_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.valid      = (estado_q == ST_RUN);
    assign bus.busy       = (estado_q != ST_IDLE);
    assign bus.fim_linha  = bus.valid && x_wrap && rep_x_ult && rep_l_ult;
    assign bus.fim_quadro = bus.valid && ultimo;
    assign bus.done       = done_q;
    assign bus.erro       = erro_q;

endmodule

// File: tb/tb_contador_varredura_xy.sv
// tb/tb_contador_varredura_xy.sv - directed self-checking bench for contador_varredura_xy
module tb_contador_varredura_xy;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    contador_varredura_xy_if #(.W_BITS(10), .H_BITS(10), .P_BITS(3)) bus ();

    contador_varredura_xy #(.W_BITS(10), .H_BITS(10), .P_BITS(3)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // {valid, cont_x, cont_y, fim_linha, fim_quadro}
    logic [22:0] got, exp;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic start_frame(input int l, input int a, input int p);
        bus.largura_max = 10'(l);
        bus.altura_max  = 10'(a);
        bus.passo       = 3'(p);
        bus.start       = 1'b1;
        tick();
        bus.start       = 1'b0;
    endtask

    task automatic test_reset;
        bus.config_mudou = 1'b0;
        bus.start        = 1'b0;
        bus.enable       = 1'b0;
        bus.largura_max  = '0;
        bus.altura_max   = '0;
        bus.passo        = '0;
`ifdef ZOOM_REPEAT_EN
        bus.fator        = 3'd1;
`endif
        #12;
        checks++;
        if ({bus.cont_x, bus.cont_y, bus.valid, bus.busy, bus.done, bus.erro, bus.fim_linha, bus.fim_quadro} !== 26'd0) begin
            failures++;
            $display("FAIL reset_state got x=%0d y=%0d v=%b b=%b d=%b e=%b required all 0",
                     bus.cont_x, bus.cont_y, bus.valid, bus.busy, bus.done, bus.erro);
        end
        @(negedge clock);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_raster;
        start_frame(4, 3, 1);
        bus.largura_max = 10'd7;
        bus.altura_max  = 10'd9;
        bus.enable      = 1'b1;
        for (int i = 0; i < 12; i++) begin
            got = {bus.valid, bus.cont_x, bus.cont_y, bus.fim_linha, bus.fim_quadro};
            exp = {1'b1, 10'(i % 4), 10'(i / 4), (i % 4) == 3, i == 11};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL raster_pos i=%0d got=%h required=%h", i, got, exp);
            end
            tick();
        end
        checks++;
        if ({bus.valid, bus.busy, bus.done, bus.cont_x, bus.cont_y} !== {3'b011, 10'd3, 10'd2}) begin
            failures++;
            $display("FAIL raster_done got v=%b b=%b d=%b x=%0d y=%0d required v=0 b=1 d=1 x=3 y=2",
                     bus.valid, bus.busy, bus.done, bus.cont_x, bus.cont_y);
        end
        tick();
        bus.enable = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.valid} !== 3'b000) begin
            failures++;
            $display("FAIL raster_idle got b=%b d=%b v=%b required 000", bus.busy, bus.done, bus.valid);
        end
    endtask

    task automatic test_passo;
        int n;
        n = 0;
        start_frame(10, 5, 3);
        bus.enable = 1'b1;
        for (int y = 0; y < 5; y += 3) begin
            for (int x = 0; x < 10; x += 3) begin
                got = {bus.valid, bus.cont_x, bus.cont_y, bus.fim_linha, bus.fim_quadro};
                exp = {1'b1, 10'(x), 10'(y), x == 9, (x == 9) && (y == 3)};
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL passo_pos n=%0d got=%h required=%h", n, got, exp);
                end
                n++;
                tick();
            end
        end
        checks++;
        if ({bus.valid, bus.done, bus.cont_x, bus.cont_y} !== {2'b01, 10'd9, 10'd3}) begin
            failures++;
            $display("FAIL passo_done got v=%b d=%b x=%0d y=%0d required v=0 d=1 x=9 y=3",
                     bus.valid, bus.done, bus.cont_x, bus.cont_y);
        end
        bus.enable = 1'b0;
        tick();
    endtask

    task automatic test_erro;
        start_frame(4, 0, 1);
        checks++;
        if ({bus.erro, bus.busy, bus.valid} !== 3'b100) begin
            failures++;
            $display("FAIL erro_alt0 got e=%b b=%b v=%b required 100", bus.erro, bus.busy, bus.valid);
        end
        tick();
        checks++;
        if ({bus.erro, bus.busy, bus.valid} !== 3'b000) begin
            failures++;
            $display("FAIL erro_pulse_end got e=%b b=%b v=%b required 000", bus.erro, bus.busy, bus.valid);
        end
        start_frame(0, 3, 1);
        checks++;
        if ({bus.erro, bus.busy, bus.valid} !== 3'b100) begin
            failures++;
            $display("FAIL erro_larg0 got e=%b b=%b v=%b required 100", bus.erro, bus.busy, bus.valid);
        end
        tick();
    endtask

    task automatic test_config;
        start_frame(4, 3, 1);
        bus.enable = 1'b1;
        repeat (6) tick();
        checks++;
        if ({bus.valid, bus.cont_x, bus.cont_y} !== {1'b1, 10'd2, 10'd1}) begin
            failures++;
            $display("FAIL cfg_pos got v=%b x=%0d y=%0d required v=1 x=2 y=1", bus.valid, bus.cont_x, bus.cont_y);
        end
        bus.config_mudou = 1'b1;
        tick();
        bus.config_mudou = 1'b0;
        bus.enable       = 1'b0;
        checks++;
        if ({bus.busy, bus.valid, bus.done, bus.cont_x, bus.cont_y} !== 23'd0) begin
            failures++;
            $display("FAIL cfg_abort got b=%b v=%b d=%b x=%0d y=%0d required all 0",
                     bus.busy, bus.valid, bus.done, bus.cont_x, bus.cont_y);
        end
        tick();
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            failures++;
            $display("FAIL cfg_no_done got b=%b d=%b required 00", bus.busy, bus.done);
        end
        start_frame(4, 3, 1);
        checks++;
        if ({bus.valid, bus.busy, bus.cont_x, bus.cont_y} !== {2'b11, 20'd0}) begin
            failures++;
            $display("FAIL cfg_restart got v=%b b=%b x=%0d y=%0d required v=1 b=1 x=0 y=0",
                     bus.valid, bus.busy, bus.cont_x, bus.cont_y);
        end
        bus.config_mudou = 1'b1;
        tick();
        bus.config_mudou = 1'b0;
    endtask

    task automatic test_gap_async;
        start_frame(4, 3, 1);
        bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.valid, bus.cont_x, bus.cont_y} !== {1'b1, 10'd1, 10'd0}) begin
            failures++;
            $display("FAIL gap_hold got v=%b x=%0d y=%0d required v=1 x=1 y=0", bus.valid, bus.cont_x, bus.cont_y);
        end
        bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
        checks++;
        if ({bus.cont_x, bus.cont_y} !== {10'd2, 10'd0}) begin
            failures++;
            $display("FAIL gap_resume got x=%0d y=%0d required x=2 y=0", bus.cont_x, bus.cont_y);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.cont_x, bus.cont_y, bus.valid, bus.busy, bus.done, bus.erro, bus.fim_linha, bus.fim_quadro} !== 26'd0) begin
            failures++;
            $display("FAIL async_reset got x=%0d y=%0d v=%b b=%b required all 0",
                     bus.cont_x, bus.cont_y, bus.valid, bus.busy);
        end
        @(negedge clock);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back;
        start_frame(2, 1, 0);
        got = {bus.valid, bus.cont_x, bus.cont_y, bus.fim_linha, bus.fim_quadro};
        checks++;
        if (got !== {1'b1, 20'd0, 2'b00}) begin
            failures++;
            $display("FAIL b2b_first got=%h required=%h", got, {1'b1, 20'd0, 2'b00});
        end
        bus.enable = 1'b1;
        tick();
        got = {bus.valid, bus.cont_x, bus.cont_y, bus.fim_linha, bus.fim_quadro};
        checks++;
        if (got !== {1'b1, 10'd1, 10'd0, 2'b11}) begin
            failures++;
            $display("FAIL b2b_step0 got=%h required=%h", got, {1'b1, 10'd1, 10'd0, 2'b11});
        end
        bus.largura_max = 10'd1;
        bus.altura_max  = 10'd1;
        bus.start       = 1'b1;
        tick();
        checks++;
        if ({bus.done, bus.busy, bus.valid} !== 3'b110) begin
            failures++;
            $display("FAIL b2b_fim got d=%b b=%b v=%b required 110", bus.done, bus.busy, bus.valid);
        end
        tick();
        checks++;
        if ({bus.done, bus.busy, bus.valid} !== 3'b000) begin
            failures++;
            $display("FAIL b2b_idle got d=%b b=%b v=%b required 000", bus.done, bus.busy, bus.valid);
        end
        tick();
        bus.start = 1'b0;
        got = {bus.valid, bus.cont_x, bus.cont_y, bus.fim_linha, bus.fim_quadro};
        checks++;
        if (got !== {1'b1, 20'd0, 2'b11}) begin
            failures++;
            $display("FAIL b2b_1x1 got=%h required=%h", got, {1'b1, 20'd0, 2'b11});
        end
        tick();
        checks++;
        if ({bus.done, bus.valid} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_1x1_done got d=%b v=%b required 10", bus.done, bus.valid);
        end
        bus.enable = 1'b0;
        tick();
    endtask

`ifdef ZOOM_REPEAT_EN
    task automatic test_repeat;
        bus.fator = 3'd2;
        start_frame(2, 2, 1);
        bus.enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            got = {bus.valid, bus.cont_x, bus.cont_y, bus.fim_linha, bus.fim_quadro};
            exp = {1'b1, 10'((i >> 1) & 1), 10'((i >> 3) & 1), (i % 8) == 7, i == 15};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL repeat_pos i=%0d got=%h required=%h", i, got, exp);
            end
            tick();
        end
        checks++;
        if ({bus.done, bus.valid} !== 2'b10) begin
            failures++;
            $display("FAIL repeat_done got d=%b v=%b required 10", bus.done, bus.valid);
        end
        bus.enable = 1'b0;
        bus.fator  = 3'd1;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_raster();
        test_passo();
        test_erro();
        test_config();
        test_gap_async();
        test_back_to_back();
`ifdef ZOOM_REPEAT_EN
        test_repeat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
